// File: rtl/q2a03_bus_unit.sv
// Q2A03 bus-cycle sequencer: divides G_clock into phi1/phi2 and runs one external bus cycle per CPU clock.
// Optional macro Q2A03_BUS_RDY_WR_EN: G_ready also stalls write cycles (default: only reads stall).
module q2a03_bus_unit #(
  parameter int DIVIDER    = 12,
  parameter int PHI1_TICKS = 6,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8
) (
  input  logic              G_clock,
  input  logic              G_reset,
  input  logic              G_ready,
  input  logic [DATA_W-1:0] G_rd_data,
  output logic [ADDR_W-1:0] G_addr,
  output logic [DATA_W-1:0] G_wr_data,
  output logic              G_rdwr,
  output logic              G_sync,
  output logic              G_phy2,
  output logic              phi1_stb,
  output logic              phi2_stb,
  input  logic              req_valid,
  input  logic              req_rdwr,
  input  logic              req_sync,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ack,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data
);

  localparam int TICK_W = $clog2(DIVIDER);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(DIVIDER - 1);
  localparam logic [TICK_W-1:0] PHI2_TICK = TICK_W'(PHI1_TICKS);

  if (DIVIDER < 2) begin : g_bad_divider
    $error("q2a03_bus_unit: DIVIDER must be at least 2");
  end
  if (PHI1_TICKS < 1 || PHI1_TICKS > DIVIDER - 1) begin : g_bad_phi1
    $error("q2a03_bus_unit: PHI1_TICKS must be in 1..DIVIDER-1");
  end

  typedef enum logic [1:0] {
    CYC_IDLE,
    CYC_READ,
    CYC_WRITE
  } cycle_e;

  cycle_e            cyc;
  logic [TICK_W-1:0] tick;
  logic              boundary;
  logic              stall;

  assign boundary = (tick == LAST_TICK);

`ifdef Q2A03_BUS_RDY_WR_EN
  assign stall = boundary & (cyc != CYC_IDLE) & ~G_ready;
`else
  assign stall = boundary & (cyc == CYC_READ) & ~G_ready;
`endif

  assign req_ack  = boundary & req_valid & ~stall;
  assign G_rdwr   = (cyc != CYC_WRITE);
  assign G_phy2   = (tick >= PHI2_TICK);
  assign phi2_stb = (tick == PHI2_TICK);
  // Gated by reset so the strobe reads 0 while reset is held even though tick sits at 0.
  assign phi1_stb = (tick == '0) & G_reset;

  // A stalled boundary leaves every bus register untouched, so the cycle simply repeats.
  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      tick      <= '0;
      cyc       <= CYC_IDLE;
      G_addr    <= '0;
      G_wr_data <= '0;
      G_sync    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      tick      <= boundary ? '0 : tick + 1'b1;
      rsp_valid <= 1'b0;
      if (boundary && !stall) begin
        rsp_valid <= (cyc != CYC_IDLE);
        if (cyc == CYC_READ) begin
          rsp_data <= G_rd_data;
        end
        if (req_valid) begin
          cyc    <= req_rdwr ? CYC_READ : CYC_WRITE;
          G_addr <= req_addr;
          G_sync <= req_sync;
          if (!req_rdwr) begin
            G_wr_data <= req_wdata;
          end
        end else begin
          cyc    <= CYC_IDLE;
          G_sync <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_q2a03_bus_unit.sv
// Randomised bench for q2a03_bus_unit: three divider configurations run side by side,
// each checked every clock against a transaction-level model of the bus cycle rules.
module tb_q2a03_bus_unit;

  localparam int N_CFG    = 3;
  localparam int N_CLOCKS = 1500;

`ifdef Q2A03_BUS_RDY_WR_EN
  localparam bit WR_STALL = 1'b1;
`else
  localparam bit WR_STALL = 1'b0;
`endif

  logic        G_clock;
  logic        G_reset   [N_CFG];
  logic        G_ready   [N_CFG];
  logic [7:0]  G_rd_data [N_CFG];
  logic [15:0] G_addr    [N_CFG];
  logic [7:0]  G_wr_data [N_CFG];
  logic        G_rdwr    [N_CFG];
  logic        G_sync    [N_CFG];
  logic        G_phy2    [N_CFG];
  logic        phi1_stb  [N_CFG];
  logic        phi2_stb  [N_CFG];
  logic        req_valid [N_CFG];
  logic        req_rdwr  [N_CFG];
  logic        req_sync  [N_CFG];
  logic [15:0] req_addr  [N_CFG];
  logic [7:0]  req_wdata [N_CFG];
  logic        req_ack   [N_CFG];
  logic        rsp_valid [N_CFG];
  logic [7:0]  rsp_data  [N_CFG];

  for (genvar g = 0; g < N_CFG; g++) begin : g_dut
    localparam int DIV = (g == 0) ? 12 : ((g == 1) ? 4 : 2);
    localparam int P1  = (g == 0) ? 6 : 1;
    q2a03_bus_unit #(
      .DIVIDER(DIV), .PHI1_TICKS(P1), .ADDR_W(16), .DATA_W(8)
    ) u_dut (
      .G_clock(G_clock), .G_reset(G_reset[g]), .G_ready(G_ready[g]),
      .G_rd_data(G_rd_data[g]), .G_addr(G_addr[g]), .G_wr_data(G_wr_data[g]),
      .G_rdwr(G_rdwr[g]), .G_sync(G_sync[g]), .G_phy2(G_phy2[g]),
      .phi1_stb(phi1_stb[g]), .phi2_stb(phi2_stb[g]),
      .req_valid(req_valid[g]), .req_rdwr(req_rdwr[g]), .req_sync(req_sync[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_ack(req_ack[g]),
      .rsp_valid(rsp_valid[g]), .rsp_data(rsp_data[g])
    );
  end

  initial G_clock = 1'b0;
  always #5 G_clock = ~G_clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: position inside the CPU cycle, the bus cycle in flight,
  // the expected response outputs and the request the core is presenting.
  int          m_pos   [N_CFG];
  bit          m_idle  [N_CFG];
  bit          m_rd    [N_CFG];
  bit          m_sync  [N_CFG];
  logic [15:0] m_addr  [N_CFG];
  logic [7:0]  m_wdata [N_CFG];
  bit          m_rsp   [N_CFG];
  logic [7:0]  m_rdata [N_CFG];
  bit          p_valid [N_CFG];
  bit          p_rd    [N_CFG];
  bit          p_sync  [N_CFG];
  logic [15:0] p_addr  [N_CFG];
  logic [7:0]  p_wdata [N_CFG];
  int          rst_hold[N_CFG];

  function automatic int div_of(int k);
    return (k == 0) ? 12 : ((k == 1) ? 4 : 2);
  endfunction

  function automatic int p1_of(int k);
    return (k == 0) ? 6 : 1;
  endfunction

  function automatic int req_pct(int k);
    return (k == 0) ? 60 : 100;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic modelReset(int k);
    m_pos[k]   = 0;
    m_idle[k]  = 1'b1;
    m_rd[k]    = 1'b1;
    m_sync[k]  = 1'b0;
    m_addr[k]  = '0;
    m_wdata[k] = '0;
    m_rsp[k]   = 1'b0;
    m_rdata[k] = '0;
  endtask

  task automatic applyStimulus(int k);
    if (rst_hold[k] > 0) begin
      rst_hold[k]--;
      if (rst_hold[k] == 0) G_reset[k] = 1'b1;
      modelReset(k);
    end else if ($urandom_range(0, 249) == 0) begin
      G_reset[k]  = 1'b0;
      rst_hold[k] = 1 + $urandom_range(0, 1);
      modelReset(k);
    end
    G_ready[k]   = ($urandom_range(0, 3) != 0);
    G_rd_data[k] = 8'($urandom);
    if (!p_valid[k] && $urandom_range(0, 99) < req_pct(k)) begin
      p_valid[k] = 1'b1;
      p_rd[k]    = ($urandom_range(0, 1) == 1);
      p_sync[k]  = p_rd[k] && ($urandom_range(0, 1) == 1);
      p_addr[k]  = ($urandom_range(0, 3) == 0) ? 16'hC000 : 16'($urandom);
      p_wdata[k] = 8'($urandom);
    end
    req_valid[k] = p_valid[k];
    req_rdwr[k]  = p_rd[k];
    req_sync[k]  = p_sync[k];
    req_addr[k]  = p_addr[k];
    req_wdata[k] = p_wdata[k];
  endtask

  function automatic bit model_stall(int k);
    return (m_pos[k] == div_of(k) - 1) && !m_idle[k] && !G_ready[k] && (m_rd[k] || WR_STALL);
  endfunction

  task automatic checkInstance(int k);
    string t;
    bit    bnd;
    t   = $sformatf("d%0d", div_of(k));
    bnd = (m_pos[k] == div_of(k) - 1);
    checkOutput({t, " G_phy2"},    32'(G_phy2[k]),    32'(m_pos[k] >= p1_of(k)));
    checkOutput({t, " phi1_stb"},  32'(phi1_stb[k]),  32'((m_pos[k] == 0) && G_reset[k]));
    checkOutput({t, " phi2_stb"},  32'(phi2_stb[k]),  32'(m_pos[k] == p1_of(k)));
    checkOutput({t, " G_addr"},    32'(G_addr[k]),    32'(m_addr[k]));
    checkOutput({t, " G_rdwr"},    32'(G_rdwr[k]),    32'(m_rd[k]));
    checkOutput({t, " G_sync"},    32'(G_sync[k]),    32'(m_sync[k]));
    checkOutput({t, " G_wr_data"}, 32'(G_wr_data[k]), 32'(m_wdata[k]));
    checkOutput({t, " req_ack"},   32'(req_ack[k]),   32'(bnd && p_valid[k] && !model_stall(k)));
    checkOutput({t, " rsp_valid"}, 32'(rsp_valid[k]), 32'(m_rsp[k]));
    checkOutput({t, " rsp_data"},  32'(rsp_data[k]),  32'(m_rdata[k]));
  endtask

  // What the upcoming rising edge does to the model: completion, acceptance or a repeated cycle.
  task automatic modelEdge(int k);
    bit bnd;
    bit stall;
    if (!G_reset[k]) return;
    bnd      = (m_pos[k] == div_of(k) - 1);
    stall    = model_stall(k);
    m_rsp[k] = 1'b0;
    if (bnd && !stall) begin
      m_rsp[k] = !m_idle[k];
      if (!m_idle[k] && m_rd[k]) m_rdata[k] = G_rd_data[k];
      if (p_valid[k]) begin
        m_idle[k] = 1'b0;
        m_rd[k]   = p_rd[k];
        m_sync[k] = p_sync[k];
        m_addr[k] = p_addr[k];
        if (!p_rd[k]) m_wdata[k] = p_wdata[k];
        p_valid[k] = 1'b0;
      end else begin
        m_idle[k] = 1'b1;
        m_rd[k]   = 1'b1;
        m_sync[k] = 1'b0;
      end
    end
    m_pos[k] = (m_pos[k] + 1) % div_of(k);
  endtask

  initial begin
    for (int k = 0; k < N_CFG; k++) begin
      G_reset[k]   = 1'b0;
      G_ready[k]   = 1'b1;
      G_rd_data[k] = '0;
      req_valid[k] = 1'b0;
      req_rdwr[k]  = 1'b1;
      req_sync[k]  = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      p_valid[k]   = 1'b0;
      p_rd[k]      = 1'b1;
      p_sync[k]    = 1'b0;
      p_addr[k]    = '0;
      p_wdata[k]   = '0;
      rst_hold[k]  = 3;
      modelReset(k);
    end
    for (int c = 0; c < N_CLOCKS; c++) begin
      @(negedge G_clock);
      for (int k = 0; k < N_CFG; k++) applyStimulus(k);
      #1;
      for (int k = 0; k < N_CFG; k++) checkInstance(k);
      for (int k = 0; k < N_CFG; k++) modelEdge(k);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
